wash_program_sequencer: RTL and testbench

//  Sequences one complete wash program: fill, agitation cycles, drain, spin.

---
 rtl/wash_pkg.sv | 77 +++++++
 rtl/wash_program_sequencer_timer.sv | 27 ++
 rtl/wash_program_sequencer.sv | 162 ++++++++++++++++
 tb/tb_wash_program_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// Shared types and timing table for the wash program sequencer.
// Optional feature macro used by the top level: DOOR_LOCK_EN.
package wash_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_FILL  = 4'd1,
    ST_FWD   = 4'd2,
    ST_REST  = 4'd3,
    ST_REV   = 4'd4,
    ST_DRAIN = 4'd5,
    ST_SPIN  = 4'd6,
    ST_DONE  = 4'd7,
    ST_HOLD  = 4'd8
  } state_t;

  localparam logic [1:0] MODE_NORM    = 2'b00;
  localparam logic [1:0] MODE_WOOL    = 2'b01;
  localparam logic [1:0] MODE_QUICK   = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  localparam logic [7:0] FILL_S      = 8'd3;
  localparam logic [7:0] REST_S      = 8'd1;
  localparam logic [7:0] DRAIN_S     = 8'd4;
  localparam logic [7:0] SPIN_S      = 8'd6;
  localparam logic [7:0] NORM_RUN_S  = 8'd10;
  localparam logic [7:0] WOOL_RUN_S  = 8'd5;
  localparam logic [7:0] QUICK_RUN_S = 8'd10;
  localparam logic [3:0] NORM_CYC    = 4'd8;
  localparam logic [3:0] WOOL_CYC    = 4'd11;
  localparam logic [3:0] QUICK_CYC   = 4'd6;

  // Agitation run time (FWD/REV) for a program mode.
  function automatic logic [7:0] run_time(input logic [1:0] m);
    case (m)
      MODE_WOOL:  run_time = WOOL_RUN_S;
      MODE_QUICK: run_time = QUICK_RUN_S;
      default:    run_time = NORM_RUN_S;
    endcase
  endfunction

  // Number of agitation cycles for a program mode.
  function automatic logic [3:0] mode_cycles(input logic [1:0] m);
    case (m)
      MODE_WOOL:  mode_cycles = WOOL_CYC;
      MODE_QUICK: mode_cycles = QUICK_CYC;
      default:    mode_cycles = NORM_CYC;
    endcase
  endfunction

  // Duration loaded into the phase timer on entry to a state.
  function automatic logic [7:0] phase_dur(input logic [1:0] m, input state_t s);
    case (s)
      ST_FILL:         phase_dur = FILL_S;
      ST_FWD, ST_REV:  phase_dur = run_time(m);
      ST_REST:         phase_dur = REST_S;
      ST_DRAIN:        phase_dur = DRAIN_S;
      ST_SPIN:         phase_dur = SPIN_S;
      default:         phase_dur = '0;
    endcase
  endfunction

  // 3-bit display code of a program state (HOLD never displayed directly).
  function automatic logic [2:0] phase_code(input state_t s);
    case (s)
      ST_FILL:  phase_code = 3'd1;
      ST_FWD:   phase_code = 3'd2;
      ST_REST:  phase_code = 3'd3;
      ST_REV:   phase_code = 3'd4;
      ST_DRAIN: phase_code = 3'd5;
      ST_SPIN:  phase_code = 3'd6;
      ST_DONE:  phase_code = 3'd7;
      default:  phase_code = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/wash_program_sequencer_timer.sv
// Per-phase seconds down-counter: load has priority, freeze blocks ticks,
// expiry flags the tick that would take the count from 1 to 0.
module wash_phase_timer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       freeze,
  input  logic       tick,
  output logic [7:0] sec_left,
  output logic       expire
);

  // Seconds counter: load, else count down on an unfrozen tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_left <= '0;
    end else if (load) begin
      sec_left <= load_val;
    end else if (tick && !freeze && (sec_left != '0)) begin
      sec_left <= sec_left - 8'd1;
    end
  end

  assign expire = tick & ~freeze & (sec_left == 8'd1);

endmodule

// File: rtl/wash_program_sequencer.sv
// Wash program sequencer: fill, agitation cycles, drain, spin, done.
// Optional feature macro: DOOR_LOCK_EN (adds door_lock and a post-spin dwell).
module wash_program_sequencer
  import wash_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       cover_closed,
  input  logic       water_connected,
  input  logic [1:0] mode,
  output logic       valve_in,
  output logic       drain_valve,
  output logic       motor_fwd,
  output logic       motor_rev,
  output logic [2:0] phase,
  output logic [3:0] cycle_cnt,
  output logic [7:0] sec_left,
  output logic       done,
`ifdef DOOR_LOCK_EN
  output logic       door_lock,
`endif
  output logic       fault
);

  state_t     state, state_nxt, saved_q;
  logic [1:0] mode_q, eff_mode;
  logic       start_d, start_rise;
  logic       rest_end, rest_end_nxt;
  logic       cnt_inc, cnt_clr;
  logic [3:0] cnt_plus;
  logic       load, freeze, expire;
  logic [7:0] load_val;
  logic       hold_cause, resume_blocked, dwell_over;

  assign start_rise = start & ~start_d;
  assign eff_mode   = (state == ST_IDLE) ? mode : mode_q;
  assign cnt_plus   = cycle_cnt + 4'd1;

  assign hold_cause     = pause | ~cover_closed | (~water_connected & (state == ST_FILL));
  assign resume_blocked = pause | ~cover_closed | (~water_connected & (saved_q == ST_FILL));

`ifdef DOOR_LOCK_EN
  assign dwell_over = (sec_left == '0);
`else
  assign dwell_over = 1'b1;
`endif

  wash_phase_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (load_val),
    .freeze   (freeze),
    .tick     (tick),
    .sec_left (sec_left),
    .expire   (expire)
  );

  // State, saved state, latched mode, cycle count and start edge history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      saved_q   <= ST_IDLE;
      mode_q    <= MODE_NORM;
      start_d   <= 1'b0;
      rest_end  <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      state    <= state_nxt;
      start_d  <= start;
      rest_end <= rest_end_nxt;
      if (state != ST_HOLD && state_nxt == ST_HOLD) saved_q <= state;
      if (state == ST_IDLE && state_nxt == ST_FILL) mode_q <= mode;
      if (cnt_clr)      cycle_cnt <= '0;
      else if (cnt_inc) cycle_cnt <= cnt_plus;
    end
  end

  // Next-state and timer control; hold requests take priority over expiry.
  always_comb begin
    state_nxt    = state;
    load         = 1'b0;
    freeze       = 1'b0;
    cnt_inc      = 1'b0;
    cnt_clr      = 1'b0;
    rest_end_nxt = rest_end;
    case (state)
      ST_IDLE: begin
        if (start_rise && cover_closed && water_connected && mode != MODE_ILLEGAL) begin
          state_nxt = ST_FILL;
          load      = 1'b1;
        end
      end
      ST_FILL, ST_FWD, ST_REST, ST_REV, ST_DRAIN, ST_SPIN: begin
        if (hold_cause) begin
          state_nxt = ST_HOLD;
          freeze    = 1'b1;
        end else if (expire) begin
          load = 1'b1;
          case (state)
            ST_FILL:  state_nxt = ST_FWD;
            ST_FWD: begin
              state_nxt    = ST_REST;
              rest_end_nxt = 1'b0;
            end
            ST_REV: begin
              state_nxt    = ST_REST;
              rest_end_nxt = 1'b1;
            end
            ST_REST: begin
              if (!rest_end) begin
                state_nxt = ST_REV;
              end else begin
                cnt_inc   = 1'b1;
                state_nxt = (cnt_plus == mode_cycles(mode_q)) ? ST_DRAIN : ST_FWD;
              end
            end
            ST_DRAIN: state_nxt = ST_SPIN;
            ST_SPIN:  state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_HOLD: begin
        freeze = 1'b1;
        if (!resume_blocked) state_nxt = saved_q;
      end
      ST_DONE: begin
        if (!start && dwell_over) begin
          state_nxt = ST_IDLE;
          load      = 1'b1;
          cnt_clr   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    load_val = phase_dur(eff_mode, state_nxt);
`ifdef DOOR_LOCK_EN
    if (state_nxt == ST_DONE) load_val = SPIN_S;
`endif
  end

  // Actuator and status decode; HOLD shows the interrupted phase.
  always_comb begin
    valve_in    = (state == ST_FILL);
    motor_fwd   = (state == ST_FWD) || (state == ST_SPIN);
    motor_rev   = (state == ST_REV);
    drain_valve = (state == ST_DRAIN) || (state == ST_SPIN);
    phase       = (state == ST_HOLD) ? phase_code(saved_q) : phase_code(state);
    done        = (state == ST_DONE) && dwell_over;
    fault       = (state == ST_HOLD) &&
                  (!cover_closed || (!water_connected && saved_q == ST_FILL));
`ifdef DOOR_LOCK_EN
    door_lock   = (state != ST_IDLE && state != ST_DONE) ||
                  (state == ST_DONE && !dwell_over);
`endif
  end

endmodule

// File: tb/tb_wash_program_sequencer.sv
// Self-checking bench for wash_program_sequencer against a schedule-based model.
// Honours DOOR_LOCK_EN when the design is built with it.
module tb_wash_program_sequencer;

  localparam int P_FILL = 1, P_FWD = 2, P_REST = 3, P_REV = 4;
  localparam int P_DRAIN = 5, P_SPIN = 6, P_DONE = 7;
`ifdef DOOR_LOCK_EN
  localparam int DWELL = 6;
`else
  localparam int DWELL = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n, tick, start, pause, cover_closed, water_connected;
  logic [1:0] mode;
  logic       valve_in, drain_valve, motor_fwd, motor_rev, done, fault;
  logic [2:0] phase;
  logic [3:0] cycle_cnt;
  logic [7:0] sec_left;
  logic       dl;
`ifdef DOOR_LOCK_EN
  logic       door_lock;
  assign dl = door_lock;
`else
  assign dl = 1'b0;
`endif

  wash_program_sequencer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .tick            (tick),
    .start           (start),
    .pause           (pause),
    .cover_closed    (cover_closed),
    .water_connected (water_connected),
    .mode            (mode),
    .valve_in        (valve_in),
    .drain_valve     (drain_valve),
    .motor_fwd       (motor_fwd),
    .motor_rev       (motor_rev),
    .phase           (phase),
    .cycle_cnt       (cycle_cnt),
    .sec_left        (sec_left),
    .done            (done),
`ifdef DOOR_LOCK_EN
    .door_lock       (door_lock),
`endif
    .fault           (fault)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model: precomputed phase schedule ----------------
  typedef enum {M_IDLE, M_RUN, M_HOLD, M_DONE} mst_t;
  int   sch_code[$];
  int   sch_dur[$];
  int   sch_cyc[$];
  mst_t m_st;
  int   m_idx, m_rem, m_total;
  bit   m_prev_start;

  function automatic int run_s(input int md);
    return (md == 1) ? 5 : 10;
  endfunction

  function automatic int n_cyc(input int md);
    return (md == 1) ? 11 : (md == 2) ? 6 : 8;
  endfunction

  task automatic build(input int md);
    sch_code.delete(); sch_dur.delete(); sch_cyc.delete();
    sch_code.push_back(P_FILL); sch_dur.push_back(3); sch_cyc.push_back(0);
    for (int c = 0; c < n_cyc(md); c++) begin
      sch_code.push_back(P_FWD);  sch_dur.push_back(run_s(md)); sch_cyc.push_back(c);
      sch_code.push_back(P_REST); sch_dur.push_back(1);         sch_cyc.push_back(c);
      sch_code.push_back(P_REV);  sch_dur.push_back(run_s(md)); sch_cyc.push_back(c);
      sch_code.push_back(P_REST); sch_dur.push_back(1);         sch_cyc.push_back(c);
    end
    sch_code.push_back(P_DRAIN); sch_dur.push_back(4); sch_cyc.push_back(n_cyc(md));
    sch_code.push_back(P_SPIN);  sch_dur.push_back(6); sch_cyc.push_back(n_cyc(md));
    m_total = n_cyc(md);
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_idx = 0; m_rem = 0; m_total = 0; m_prev_start = 1'b0;
    sch_code.delete(); sch_dur.delete(); sch_cyc.delete();
  endtask

  function automatic bit cause(input int code);
    return pause || !cover_closed || (code == P_FILL && !water_connected);
  endfunction

  function automatic int cur_code();
    if (m_st == M_RUN || m_st == M_HOLD) return sch_code[m_idx];
    if (m_st == M_DONE) return P_DONE;
    return 0;
  endfunction

  // One clock of the model, using the inputs the DUT sampled at this edge.
  task automatic model_step();
    case (m_st)
      M_IDLE: if (start && !m_prev_start && cover_closed && water_connected && mode != 2'b11) begin
        build(int'(mode)); m_idx = 0; m_rem = sch_dur[0]; m_st = M_RUN;
      end
      M_RUN: begin
        if (cause(sch_code[m_idx])) m_st = M_HOLD;
        else if (tick) begin
          if (m_rem == 1) begin
            m_idx++;
            if (m_idx == sch_code.size()) begin m_st = M_DONE; m_rem = DWELL; end
            else m_rem = sch_dur[m_idx];
          end else m_rem--;
        end
      end
      M_HOLD: if (!cause(sch_code[m_idx])) m_st = M_RUN;
      M_DONE: begin
        if (!start && m_rem == 0) begin m_st = M_IDLE; m_rem = 0; end
        else if (tick && m_rem > 0) m_rem--;
      end
      default: m_st = M_IDLE;
    endcase
    m_prev_start = start;
  endtask

  function automatic logic [31:0] pack(input logic v, d, f, r, input logic [2:0] ph,
                                       input logic [3:0] c, input logic [7:0] s,
                                       input logic dn, ft, lk);
    return {10'd0, v, d, f, r, ph, c, s, dn, ft, lk};
  endfunction

  function automatic logic [31:0] dut_vec();
    return pack(valve_in, drain_valve, motor_fwd, motor_rev, phase, cycle_cnt, sec_left, done, fault, dl);
  endfunction

  function automatic logic [31:0] model_vec();
    int  code, cyc;
    bit  run, lk;
    code = cur_code();
    run  = (m_st == M_RUN);
    cyc  = (m_st == M_IDLE) ? 0 : (m_st == M_DONE) ? m_total : sch_cyc[m_idx];
    lk   = (DWELL > 0) && (run || m_st == M_HOLD || (m_st == M_DONE && m_rem != 0));
    return pack(run && code == P_FILL,
                run && (code == P_DRAIN || code == P_SPIN),
                run && (code == P_FWD || code == P_SPIN),
                run && code == P_REV,
                3'(code), 4'(cyc), 8'(m_rem),
                m_st == M_DONE && m_rem == 0,
                m_st == M_HOLD && (!cover_closed || (code == P_FILL && !water_connected)),
                lk);
  endfunction

  // ---------------- clocking helpers ----------------
  int tick_period = 4;
  int tick_ctr    = 0;

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("outputs", dut_vec(), model_vec());
    check_eq("fwd_rev_excl", {31'd0, motor_fwd & motor_rev}, 32'd0);
  endtask

  task automatic clk1();
    tick     = (tick_ctr == 0);
    tick_ctr = (tick_ctr + 1) % tick_period;
    step();
  endtask

  task automatic run_to_done(input int bound);
    for (int i = 0; i < bound && !(m_st == M_DONE && m_rem == 0); i++) clk1();
  endtask

  task automatic finish_to_idle();
    start = 1'b0;
    for (int i = 0; i < 5; i++) clk1();
    check_eq("back_to_idle", {25'd0, phase, cycle_cnt}, 32'd0);
  endtask

  int dist_cnt = 0;
  task automatic rand_clk();
    if (dist_cnt > 0) begin
      dist_cnt--;
      if (dist_cnt == 0) begin pause = 1'b0; cover_closed = 1'b1; water_connected = 1'b1; end
    end else if ($urandom_range(0, 149) == 0) begin
      case ($urandom_range(0, 2))
        0:       pause = 1'b1;
        1:       cover_closed = 1'b0;
        default: water_connected = 1'b0;
      endcase
      dist_cnt = $urandom_range(1, 15);
    end
    if ($urandom_range(0, 99) == 0) mode = 2'($urandom_range(0, 3));
    clk1();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; tick = 1'b0; start = 1'b0; pause = 1'b0;
    cover_closed = 1'b1; water_connected = 1'b1; mode = 2'b00;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", dut_vec(), 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) clk1();

    // Normal program, tick every 4 clocks.
    tick_period = 4; tick_ctr = 0;
    mode = 2'b00; start = 1'b1;
    run_to_done(20000);
    check_eq("norm_done", {28'd0, done, phase}, {28'd0, 1'b1, 3'd7});
    check_eq("norm_cycles", cycle_cnt, 32'd8);
    finish_to_idle();

    // Wool and quick cycle counts, wool run time.
    tick_period = 2; tick_ctr = 0;
    mode = 2'b01; start = 1'b1;
    for (int i = 0; i < 2000 && !(m_st == M_RUN && sch_code[m_idx] == P_FWD); i++) clk1();
    check_eq("wool_fwd_len", {21'd0, phase, sec_left}, {21'd0, 3'd2, 8'd5});
    run_to_done(20000);
    check_eq("wool_cycles", cycle_cnt, 32'd11);
    finish_to_idle();
    mode = 2'b10; start = 1'b1;
    run_to_done(20000);
    check_eq("quick_cycles", cycle_cnt, 32'd6);
    finish_to_idle();

    // Pause in FWD at sec_left 7, then resume at 7.
    tick_period = 4; tick_ctr = 0;
    mode = 2'b00; start = 1'b1;
    for (int i = 0; i < 2000 && !(m_st == M_RUN && sch_code[m_idx] == P_FWD && m_rem == 7); i++) clk1();
    pause = 1'b1;
    for (int i = 0; i < 12; i++) clk1();
    check_eq("pause_hold", {20'd0, phase, sec_left, motor_fwd, motor_rev, fault},
             {20'd0, 3'd2, 8'd7, 3'b000});
    pause = 1'b0;
    clk1();
    check_eq("pause_resume", {23'd0, motor_fwd, sec_left}, {23'd0, 1'b1, 8'd7});

    // Cover opens in SPIN.
    run_to_done(0);
    for (int i = 0; i < 20000 && !(m_st == M_RUN && sch_code[m_idx] == P_SPIN); i++) clk1();
    cover_closed = 1'b0;
    for (int i = 0; i < 6; i++) clk1();
    check_eq("cover_hold", {26'd0, phase, fault, drain_valve, motor_fwd},
             {26'd0, 3'd6, 3'b100});
    cover_closed = 1'b1;
    clk1();
    check_eq("cover_resume", {30'd0, drain_valve, motor_fwd}, 32'd3);
    run_to_done(2000);
    finish_to_idle();

    // Refused starts: illegal mode, open cover.
    mode = 2'b11; start = 1'b1;
    for (int i = 0; i < 6; i++) clk1();
    check_eq("illegal_mode_idle", dut_vec(), 32'd0);
    start = 1'b0; mode = 2'b00; clk1();
    cover_closed = 1'b0; start = 1'b1;
    for (int i = 0; i < 6; i++) clk1();
    check_eq("cover_open_idle", dut_vec(), 32'd0);
    cover_closed = 1'b1;
    for (int i = 0; i < 3; i++) clk1();
    check_eq("no_edge_no_start", {29'd0, phase}, 32'd0);
    start = 1'b0; clk1();

    // Reset asserted mid-REV.
    start = 1'b1;
    for (int i = 0; i < 2000 && !(m_st == M_RUN && sch_code[m_idx] == P_REV); i++) clk1();
    reset_n = 1'b0;
    #1;
    check_eq("reset_mid_rev", dut_vec(), 32'd0);
    model_reset();
    start = 1'b0; tick = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) clk1();
    check_eq("no_resume", {29'd0, phase}, 32'd0);

    // Randomized programs with disturbances and mode changes.
    for (int p = 0; p < 6; p++) begin
      tick_period = $urandom_range(1, 6); tick_ctr = 0;
      mode = 2'($urandom_range(0, 3));
      start = 1'b1;
      for (int i = 0; i < 20000 && !(m_st == M_DONE && m_rem == 0 && dist_cnt == 0); i++) begin
        if (m_st == M_IDLE && i > 8) break;
        rand_clk();
      end
      pause = 1'b0; cover_closed = 1'b1; water_connected = 1'b1; dist_cnt = 0;
      clk1();
      run_to_done(20000);
      finish_to_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  always @(negedge clk)
    assert (!(motor_fwd && motor_rev)) else $error("motor_fwd and motor_rev both set");

endmodule
